// File: rtl/key_filter_if.sv
// Key conditioning signal bundle: raw pad input plus debounced level and event pulses.
// master drives the pad; slave is the key_filter that produces the conditioned outputs.
interface key_filter_if;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_filter.sv
// Active-low push-button conditioner: 2-FF synchroniser, debounce counter, press/release FSM
// and a saturating hold counter that raises a single long-press pulse per press.
module key_filter #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 50_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    key_filter_if.slave kif
);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    typedef enum logic [1:0] {StIdle, StPressFilt, StDown, StRelFilt} state_t;

    state_t             state_q, state_d;
    logic               key_meta, key_s;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic               differ, deb_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta  <= 1'b1;
            key_s     <= 1'b1;
            state_q   <= StIdle;
            deb_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            key_meta  <= kif.key_in;
            key_s     <= key_meta;
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // Any sample agreeing with the accepted level restarts the debounce window.
    assign differ   = (key_s != level_q);
    assign deb_done = differ && (deb_q == DEB_LAST);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        deb_d     = '0;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (differ && !deb_done) begin
            deb_d = deb_q + 1'b1;
        end

        // Hold time keeps accruing through a release bounce; saturation blocks auto-repeat.
        if (state_q == StDown || state_q == StRelFilt) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
            long_d = (hold_q == HOLD_LAST);
        end

        unique case (state_q)
            StIdle: begin
                if (!key_s) state_d = StPressFilt;
            end
            StPressFilt: begin
                if (key_s) begin
                    state_d = StIdle;
                end else if (deb_done) begin
                    state_d = StDown;
                    level_d = 1'b0;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            StDown: begin
                if (key_s) state_d = StRelFilt;
            end
            StRelFilt: begin
                if (!key_s) begin
                    state_d = StDown;
                end else if (deb_done) begin
                    state_d   = StIdle;
                    level_d   = 1'b1;
                    release_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: expected pulses are queued with their due cycle as stimulus
// is driven, and a negedge monitor pops and compares each pulse the DUT emits.
module tb_key_filter;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 40;

    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_LONG    = 3;

    typedef struct packed {
        int kind;
        int cyc;
    } ev_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;
    int   compared  = 0;
    int   mismatched = 0;
    ev_t  exp_q[$];

    key_filter_if kif ();

    key_filter #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kif       (kif.slave)
    );

    initial forever #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Observed/expected encoded as kind*100000 + cycle; -1 means nothing was pending.
    task automatic check_pulse(input logic p, input int kind, input string tag);
        int obs;
        int expv;
        if (p === 1'b1) begin
            obs  = kind * 100000 + cyc;
            expv = -1;
            if (exp_q.size() > 0) begin
                expv = exp_q[0].kind * 100000 + exp_q[0].cyc;
                void'(exp_q.pop_front());
            end
            compared++;
            assert (obs === expv) else begin
                mismatched++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        int due;
        if (sys_rst_n) begin
            check_pulse(kif.key_long, K_LONG, "long_pulse");
            check_pulse(kif.key_press, K_PRESS, "press_pulse");
            check_pulse(kif.key_release, K_RELEASE, "release_pulse");
            due = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                due = exp_q[0].kind * 100000 + exp_q[0].cyc;
                void'(exp_q.pop_front());
            end
            compared++;
            assert (due === 0) else begin
                mismatched++;
                $error("FAIL missed_pulse observed=none expected=%0d at_cycle=%0d", due, cyc);
            end
        end
    end

    task automatic drive(input logic v);
        @(negedge sys_clk);
        kif.key_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int t0;
        kif.key_in = 1'b0;

        // Reset held with the key down: nothing may leak through.
        idle(3);
        chk("rst_level", int'(kif.key_level), 1);
        chk("rst_press", int'(kif.key_press), 0);
        chk("rst_release", int'(kif.key_release), 0);
        chk("rst_long", int'(kif.key_long), 0);

        // Release reset with key still down: one press, DEB+1 edges after the first sample.
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        expect_ev(K_PRESS, cyc + DEB + 2);
        idle(20);
        chk("held_level", int'(kif.key_level), 0);

        // Clean release.
        drive(1'b1);
        expect_ev(K_RELEASE, cyc + DEB + 2);
        idle(15);
        chk("rel_level", int'(kif.key_level), 1);

        // Bounce: ten 3-cycle segments, then settle low.
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 1);
            idle(2);
        end
        chk("bounce_level", int'(kif.key_level), 1);
        drive(1'b0);
        expect_ev(K_PRESS, cyc + DEB + 2);
        idle(15);
        chk("bounce_held", int'(kif.key_level), 0);
        drive(1'b1);
        expect_ev(K_RELEASE, cyc + DEB + 2);
        idle(15);

        // Glitch one cycle short of the debounce window.
        drive(1'b0);
        idle(DEB - 2);
        drive(1'b1);
        idle(15);
        chk("glitch_level", int'(kif.key_level), 1);

        // Long press with a short release bounce inside the hold window.
        drive(1'b0);
        t0 = cyc;
        expect_ev(K_PRESS, t0 + DEB + 2);
        expect_ev(K_LONG, t0 + DEB + 2 + LONG);
        idle(24);
        drive(1'b1);
        idle(4);
        drive(1'b0);
        idle(65);
        chk("long_level", int'(kif.key_level), 0);
        drive(1'b1);
        expect_ev(K_RELEASE, cyc + DEB + 2);
        idle(15);
        chk("long_rel_level", int'(kif.key_level), 1);

        // Release debounce completes on the same cycle as the long pulse.
        drive(1'b0);
        t0 = cyc;
        expect_ev(K_PRESS, t0 + DEB + 2);
        expect_ev(K_LONG, t0 + DEB + 2 + LONG);
        expect_ev(K_RELEASE, t0 + DEB + 2 + LONG);
        idle(LONG - 1);
        drive(1'b1);
        idle(20);
        chk("coincide_level", int'(kif.key_level), 1);

        // Reset after 20 hold cycles: level returns high at once, press restarts.
        drive(1'b0);
        t0 = cyc;
        expect_ev(K_PRESS, t0 + DEB + 2);
        idle(DEB + 2 + 20);
        chk("pre_rst_level", int'(kif.key_level), 0);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_level", int'(kif.key_level), 1);
        chk("midrst_pulses", int'({kif.key_press, kif.key_release, kif.key_long}), 0);
        idle(2);
        sys_rst_n = 1'b1;
        expect_ev(K_PRESS, cyc + DEB + 2);
        idle(15);
        chk("fresh_level", int'(kif.key_level), 0);
        drive(1'b1);
        expect_ev(K_RELEASE, cyc + DEB + 2);
        idle(15);
        chk("final_level", int'(kif.key_level), 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
